// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider bank.
//
// Contents:
//   CNT_W_DEFAULT     default divisor/counter width
//   DIV_DISABLED_MAX  largest divisor value that leaves a channel disabled
//   hi_count(n)       number of high cycles in an n-cycle period (ceil(n/2))
package clkdiv_pkg;

  localparam int CNT_W_DEFAULT    = 8;
  localparam int DIV_DISABLED_MAX = 1;

  function automatic int unsigned hi_count(input int unsigned n);
    return n - (n / 2);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, divisor register, boundary-apply logic and
// the registered clk_out / tick outputs.
//
// Ports:
//   clock      master clock (posedge)
//   reset      asynchronous active-high reset
//   resync     force phase realignment this edge (tie 0 when unused)
//   apply_req  a pending divisor targets this channel
//   new_div    pending divisor value
//   clk_out    divided clock, registered
//   tick       one-cycle pulse on the edge where clk_out rises, registered
//   applied    combinational: the pending divisor is taken on this edge
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             resync,
  input  logic             apply_req,
  input  logic [CNT_W-1:0] new_div,
  output logic             clk_out,
  output logic             tick,
  output logic             applied
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] hi;
  logic             disabled;
  logic             at_wrap;

  always_comb begin
    disabled = (32'(div) <= DIV_DISABLED_MAX);
    at_wrap  = !disabled && (cnt == div - CNT_W'(1));
    hi       = CNT_W'(hi_count(32'(div)));
    // A disabled channel has no period boundary, so it takes the new
    // divisor on the first edge it is offered one.
    applied  = apply_req && (resync || disabled || at_wrap);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      div     <= CNT_W'(DEFAULT_DIV);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (resync) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      if (apply_req) div <= new_div;
    end else if (applied) begin
      // Boundary edge: hold the output low for this cycle so the new
      // waveform starts cleanly on the next edge without a runt pulse.
      div     <= new_div;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (disabled) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      clk_out <= (cnt < hi);
      tick    <= (cnt == '0);
      cnt     <= at_wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH runtime-programmable integer clock dividers.
//
// Optional feature: define CLKDIV_RESYNC_EN to add the resync input, which
// restarts every channel in phase (and applies any pending request).
//
// Ports:
//   clock      master clock (posedge)
//   reset      asynchronous active-high reset
//   resync     (CLKDIV_RESYNC_EN only) realign all channels
//   cfg_valid  config request valid
//   cfg_ready  bank can accept a config request
//   cfg_ch     target channel index
//   cfg_div    new divisor
//   cfg_err    one-cycle pulse after an accepted out-of-range request
//   clk_out    divided clocks, registered
//   tick       per-channel rising-edge pulses, registered
//   locked     no reconfiguration pending
//
// Handshake: a request transfers on any posedge where cfg_valid && cfg_ready;
// cfg_ready is low exactly while the single pending slot is occupied, and the
// requester must hold cfg_ch/cfg_div stable while cfg_valid is high and
// cfg_ready is low.
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                                        clock,
  input  logic                                        reset,
`ifdef CLKDIV_RESYNC_EN
  input  logic                                        resync,
`endif
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                            cfg_div,
  output logic                                        cfg_err,
  output logic [NUM_CH-1:0]                           clk_out,
  output logic [NUM_CH-1:0]                           tick,
  output logic                                        locked
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              pending;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_div;
  logic              accept;
  logic              ch_ok;
  logic              resync_i;
  logic [NUM_CH-1:0] apply_req;
  logic [NUM_CH-1:0] applied;

`ifdef CLKDIV_RESYNC_EN
  assign resync_i = resync;
`else
  assign resync_i = 1'b0;
`endif

  assign cfg_ready = !pending;
  assign locked    = !pending;
  assign accept    = cfg_valid && cfg_ready;
  // Widened so the check stays meaningful when NUM_CH is a power of two.
  assign ch_ok     = (32'(cfg_ch) < 32'(NUM_CH));

  // The slot is single-entry, so accept (slot empty) and apply (slot full)
  // never coincide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      pend_ch  <= '0;
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (accept) begin
        if (ch_ok) begin
          pending  <= 1'b1;
          pend_ch  <= cfg_ch;
          pend_div <= cfg_div;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (|applied) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply_req[i] = pending && (pend_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .resync    (resync_i),
      .apply_req (apply_req[i]),
      .new_div   (pend_div),
      .clk_out   (clk_out[i]),
      .tick      (tick[i]),
      .applied   (applied[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed testbench for clock_divider_bank (4-channel main instance plus a
// 3-channel instance used where an out-of-range channel index is encodable).
module tb_clock_divider_bank;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic       resync = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_err;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic       locked;

  logic       cfg3_valid = 1'b0;
  logic       cfg3_ready;
  logic [1:0] cfg3_ch = '0;
  logic [7:0] cfg3_div = '0;
  logic       cfg3_err;
  logic [2:0] clk3;
  logic [2:0] tick3;
  logic       locked3;

  clock_divider_bank #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(2)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef CLKDIV_RESYNC_EN
    .resync    (resync),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .locked    (locked)
  );

  clock_divider_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(2)) dut3 (
    .clock     (clock),
    .reset     (reset),
`ifdef CLKDIV_RESYNC_EN
    .resync    (resync),
`endif
    .cfg_valid (cfg3_valid),
    .cfg_ready (cfg3_ready),
    .cfg_ch    (cfg3_ch),
    .cfg_div   (cfg3_div),
    .cfg_err   (cfg3_err),
    .clk_out   (clk3),
    .tick      (tick3),
    .locked    (locked3)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic wait_locked(input string tag);
    for (int k = 0; k < 20 && locked !== 1'b1; k++) step();
    check(tag, 32'(locked), 32'd1);
  endtask

  // ---------------- expected tables ----------------
  // Edges 6..14: ch1 reprogrammed to N=3 (accepted on edge 6, applied on 8).
  logic [3:0] t2_clk [9] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0010,
                             4'b1101, 4'b0010, 4'b1111, 4'b0000};
  logic [3:0] t2_tick[9] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000,
                             4'b1101, 4'b0010, 4'b1101, 4'b0000};
  logic       t2_lock[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  // Edges 15..25: ch2 disabled (div 0), then re-enabled with div 4.
  logic t3_clk [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic t3_tick[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic t3_lock[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    #2;
    check("rst_clk", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_locked", 32'(locked), 32'd1);
    check("rst_err", 32'(cfg_err), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    check("rst_hold_clk", 32'(clk_out), 32'h0);
    reset  = 1'b0;
    edge_n = 0;

    // Default N=2 on all channels
    for (int k = 0; k < 4; k++) begin
      step();
      check("def_clk", 32'(clk_out), (k % 2 == 0) ? 32'hF : 32'h0);
      check("def_tick", 32'(tick), (k % 2 == 0) ? 32'hF : 32'h0);
      check("def_locked", 32'(locked), 32'd1);
    end
    step(); // edge 5

    // ch1 -> N=3
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 0) begin
        cfg_valid = 1'b0;
        check("n3_ready_low", 32'(cfg_ready), 32'd0);
      end
      check("n3_clk", 32'(clk_out), 32'(t2_clk[k]));
      check("n3_tick", 32'(tick), 32'(t2_tick[k]));
      check("n3_locked", 32'(locked), 32'(t2_lock[k]));
    end

    // ch2 disable, then enable with N=4
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    for (int k = 0; k < 11; k++) begin
      step();
      if (k == 0) cfg_valid = 1'b0;
      if (k == 3) begin cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4; end
      if (k == 4) cfg_valid = 1'b0;
      check("dis_clk2", 32'(clk_out[2]), 32'(t3_clk[k]));
      check("dis_tick2", 32'(tick[2]), 32'(t3_tick[k]));
      check("dis_locked", 32'(locked), 32'(t3_lock[k]));
      check("dis_err", 32'(cfg_err), 32'd0);
    end

    // Out-of-range channel on the 3-channel instance (still at N=2)
    cfg3_valid = 1'b1; cfg3_ch = 2'd3; cfg3_div = 8'd7;
    step();
    cfg3_valid = 1'b0;
    check("oor_err_pulse", 32'(cfg3_err), 32'd1);
    check("oor_ready", 32'(cfg3_ready), 32'd1);
    check("oor_locked", 32'(locked3), 32'd1);
    check("oor_clk", 32'(clk3), (edge_n % 2 == 1) ? 32'h7 : 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("oor_err_clear", 32'(cfg3_err), 32'd0);
      check("oor_ready_hold", 32'(cfg3_ready), 32'd1);
      check("oor_clk_kept", 32'(clk3), (edge_n % 2 == 1) ? 32'h7 : 32'h0);
      check("oor_tick_kept", 32'(tick3), (edge_n % 2 == 1) ? 32'h7 : 32'h0);
    end
    cfg3_valid = 1'b1; cfg3_ch = 2'd2; cfg3_div = 8'd3;
    step();
    cfg3_valid = 1'b0;
    check("inr_err", 32'(cfg3_err), 32'd0);
    check("inr_locked", 32'(locked3), 32'd0);

    // Reset mid-reconfig with ch3 at N=8
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd8;
    step();
    cfg_valid = 1'b0;
    wait_locked("n8_apply");
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    check("mid_pending", 32'(locked), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_clk", 32'(clk_out), 32'h0);
    check("async_tick", 32'(tick), 32'h0);
    check("async_locked", 32'(locked), 32'd1);
    check("async_ready", 32'(cfg_ready), 32'd1);
    check("async_clk3", 32'(clk3), 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset  = 1'b0;
    edge_n = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_rst_clk", 32'(clk_out), (k % 2 == 0) ? 32'hF : 32'h0);
      check("post_rst_tick", 32'(tick), (k % 2 == 0) ? 32'hF : 32'h0);
      check("post_rst_locked", 32'(locked), 32'd1);
    end

`ifdef CLKDIV_RESYNC_EN
    // Resync: ch0 N=4, ch1 N=6, then realign
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    wait_locked("rs_ch0");
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd6;
    step();
    cfg_valid = 1'b0;
    wait_locked("rs_ch1");
    step(); step(); step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("rs_clk_low", 32'(clk_out), 32'h0);
    check("rs_tick_low", 32'(tick), 32'h0);
    step();
    check("rs_clk_aligned", 32'(clk_out), 32'hF);
    check("rs_tick_aligned", 32'(tick), 32'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
